ps2_tx: RTL and testbench



---
 rtl/ps2_tx.sv | 264 ++++++++++++++++++++++++++
 tb/tb_ps2_tx.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_tx.sv
// ps2_tx: host-to-device PS/2 transmitter for a single command byte.
// Drives the open-collector clock/data pair through ps2CkOe/ps2DQOe (1 = pull low).
// Optional feature: define PS2_TX_RETRY_EN to resend a failed byte up to two more
// times before reporting err.
module ps2_tx #(
  parameter int unsigned INHIBIT = 720,
  parameter int unsigned TIMEOUT = 90000,
  parameter int unsigned FILTER  = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       ps2CkI,
  input  logic       ps2DQI,
  output logic       ps2CkOe,
  output logic       ps2DQOe,
  input  logic       strb,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned INH_W = $clog2(INHIBIT + 1);
  localparam int unsigned TO_W  = 17;
  localparam int unsigned FLT_W = $clog2(FILTER + 1);
  localparam int unsigned N_W   = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_TXBITS,
    S_WAITREL,
    S_DONE,
    S_ERR
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         sh_q, sh_d;
  logic               par_q, par_d;
  logic [INH_W-1:0]   inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [N_W-1:0]     n_q, n_d;
  logic               ck_oe_q, ck_oe_d;
  logic               dq_oe_q, dq_oe_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               ck_s1_q, ck_s1_d;
  logic               ck_s2_q, ck_s2_d;
  logic               dq_s1_q, dq_s1_d;
  logic               dq_s2_q, dq_s2_d;
  logic               ckf_q, ckf_d;
  logic [FLT_W-1:0]   fcnt_q, fcnt_d;
  logic               fall_c;
  logic               fail_c;

`ifdef PS2_TX_RETRY_EN
  logic [1:0]         retry_q, retry_d;
`endif

  // Line synchronisers and clock glitch filter; fall_c marks an accepted 1->0 edge.
  always_comb begin
    ck_s1_d = ps2CkI;
    ck_s2_d = ck_s1_q;
    dq_s1_d = ps2DQI;
    dq_s2_d = dq_s1_q;
    ckf_d   = ckf_q;
    fcnt_d  = fcnt_q;
    if (ck_s2_q == ckf_q) begin
      fcnt_d = '0;
    end else if (fcnt_q == FLT_W'(FILTER - 1)) begin
      ckf_d  = ck_s2_q;
      fcnt_d = '0;
    end else begin
      fcnt_d = fcnt_q + FLT_W'(1);
    end
    fall_c = ckf_q & ~ckf_d;
  end

  // Transfer sequencing: next state, counters and next registered line/status values.
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    par_d     = par_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = to_cnt_q;
    n_d       = n_q;
    ck_oe_d   = ck_oe_q;
    dq_oe_d   = dq_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    fail_c    = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_d   = retry_q;
`endif

    case (state_q)
      S_IDLE: begin
        ck_oe_d = 1'b0;
        dq_oe_d = 1'b0;
        busy_d  = 1'b0;
        if (strb) begin
          sh_d      = data;
          par_d     = ~^data;
          inh_cnt_d = INH_W'(INHIBIT - 1);
          ck_oe_d   = 1'b1;
          dq_oe_d   = 1'b0;
          busy_d    = 1'b1;
          state_d   = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_d   = 2'd0;
`endif
        end
      end

      S_INHIBIT: begin
        if (inh_cnt_q == INH_W'(0)) begin
          // Release the clock with the start bit already on the data line.
          ck_oe_d  = 1'b0;
          dq_oe_d  = 1'b1;
          to_cnt_d = '0;
          n_d      = '0;
          state_d  = S_START;
        end else begin
          inh_cnt_d = inh_cnt_q - INH_W'(1);
          if (inh_cnt_q == INH_W'(1)) begin
            dq_oe_d = 1'b1;
          end
        end
      end

      S_START, S_TXBITS: begin
        if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          fail_c = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (fall_c) begin
            n_d     = n_q + N_W'(1);
            state_d = S_TXBITS;
            if (n_q <= N_W'(7)) begin
              dq_oe_d = ~sh_q[n_q[2:0]];
            end else if (n_q == N_W'(8)) begin
              dq_oe_d = ~par_q;
            end else if (n_q == N_W'(9)) begin
              dq_oe_d = 1'b0;
            end else if (!dq_s2_q) begin
              state_d = S_WAITREL;
            end else begin
              fail_c = 1'b1;
            end
          end
        end
      end

      S_WAITREL: begin
        if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          fail_c = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (ckf_q && dq_s2_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end
        end
      end

      S_DONE, S_ERR: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        ck_oe_d = 1'b0;
        dq_oe_d = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // No ack or timeout: either restart the attempt or give up with err.
    if (fail_c) begin
`ifdef PS2_TX_RETRY_EN
      if (retry_q != 2'd2) begin
        retry_d   = retry_q + 2'd1;
        inh_cnt_d = INH_W'(INHIBIT - 1);
        ck_oe_d   = 1'b1;
        dq_oe_d   = 1'b0;
        state_d   = S_INHIBIT;
      end else begin
        ck_oe_d = 1'b0;
        dq_oe_d = 1'b0;
        busy_d  = 1'b0;
        err_d   = 1'b1;
        state_d = S_ERR;
      end
`else
      ck_oe_d = 1'b0;
      dq_oe_d = 1'b0;
      busy_d  = 1'b0;
      err_d   = 1'b1;
      state_d = S_ERR;
`endif
    end
  end

  // State and output registers; everything advances on ce, reset acts on any edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      sh_q      <= '0;
      par_q     <= 1'b0;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
      n_q       <= '0;
      ck_oe_q   <= 1'b0;
      dq_oe_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ck_s1_q   <= 1'b1;
      ck_s2_q   <= 1'b1;
      dq_s1_q   <= 1'b1;
      dq_s2_q   <= 1'b1;
      ckf_q     <= 1'b1;
      fcnt_q    <= '0;
`ifdef PS2_TX_RETRY_EN
      retry_q   <= 2'd0;
`endif
    end else if (ce) begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      par_q     <= par_d;
      inh_cnt_q <= inh_cnt_d;
      to_cnt_q  <= to_cnt_d;
      n_q       <= n_d;
      ck_oe_q   <= ck_oe_d;
      dq_oe_q   <= dq_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ck_s1_q   <= ck_s1_d;
      ck_s2_q   <= ck_s2_d;
      dq_s1_q   <= dq_s1_d;
      dq_s2_q   <= dq_s2_d;
      ckf_q     <= ckf_d;
      fcnt_q    <= fcnt_d;
`ifdef PS2_TX_RETRY_EN
      retry_q   <= retry_d;
`endif
    end
  end

  assign ps2CkOe = ck_oe_q;
  assign ps2DQOe = dq_oe_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx: randomized bench for ps2_tx with a behavioural PS/2 keyboard model.
// Timing parameters are scaled down to keep the run short.
module tb_ps2_tx;

  localparam int unsigned INH = 72;
  localparam int unsigned TO  = 1500;
  localparam int unsigned FLT = 4;
`ifdef PS2_TX_RETRY_EN
  localparam int ATT = 3;
`else
  localparam int ATT = 1;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ce    = 1'b0;
  logic       strb  = 1'b0;
  logic [7:0] data  = 8'h00;
  logic       dev_ck = 1'b0;
  logic       dev_dq = 1'b0;
  logic       ps2CkI, ps2DQI, ps2CkOe, ps2DQOe, busy, done, err;

  int errors = 0;
  int checks = 0;

  // Open-collector wiring: a line is low if either side pulls it.
  assign ps2CkI = ~(ps2CkOe | dev_ck);
  assign ps2DQI = ~(ps2DQOe | dev_dq);

  ps2_tx #(.INHIBIT(INH), .TIMEOUT(TO), .FILTER(FLT)) dut (
    .clock   (clock),
    .reset   (reset),
    .ce      (ce),
    .ps2CkI  (ps2CkI),
    .ps2DQI  (ps2DQI),
    .ps2CkOe (ps2CkOe),
    .ps2DQOe (ps2DQOe),
    .strb    (strb),
    .data    (data),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clock = ~clock;

  // ce on every other clock edge
  initial forever begin
    @(negedge clock);
    ce = ~ce;
  end

  // Per-tick observer of the DUT outputs
  int   tick_no = 0, n_done = 0, n_err = 0, n_inh = 0;
  int   run_len = 0, last_low_len = 0, rel_tick = 0, err_tick = 0, busy_bad = 0;
  logic prev_ck = 1'b0, prev_busy = 1'b0;
  initial forever begin
    @(posedge clock);
    if (ce) begin
      #1;
      tick_no++;
      if (ps2CkOe) begin
        if (!prev_ck) begin
          n_inh++;
          run_len = 1;
        end else begin
          run_len++;
        end
      end else if (prev_ck) begin
        last_low_len = run_len;
        rel_tick = tick_no;
      end
      if (done) begin
        n_done++;
        if (busy || !prev_busy) busy_bad++;
      end
      if (err) begin
        n_err++;
        err_tick = tick_no;
      end
      prev_ck = ps2CkOe;
      prev_busy = busy;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clock);
      while (ce !== 1'b1) @(posedge clock);
      #2;
    end
  endtask

  // Expected line levels: start, 8 data bits LSB first, odd parity, stop.
  function automatic logic [10:0] frame_model(input logic [7:0] d);
    logic [10:0] f;
    int ones;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = d[i];
      ones += int'(d[i]);
    end
    f[9]  = ((ones % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic send_req(input logic [7:0] d);
    data = d;
    strb = 1'b1;
    ticks(1);
    strb = 1'b0;
    data = 8'($urandom);
  endtask

  // Keyboard model: waits for the host to release the clock, then clocks 11 falls.
  task automatic dev_frame(input int half, input bit ack, input int glitch_at,
                           input int abort_at, output logic [10:0] got, output bit ok);
    int w;
    got = '0;
    ok = 1'b1;
    w = 0;
    while (ps2CkOe !== 1'b1 && w < int'(INH) + 20) begin ticks(1); w++; end
    w = 0;
    while (ps2CkOe !== 1'b0 && w < int'(INH) + 20) begin ticks(1); w++; end
    if (ps2CkOe !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    for (int f = 1; f <= 11; f++) begin
      if (f == glitch_at) begin
        ticks(half / 2);
        dev_ck = 1'b1;
        ticks(2);
        dev_ck = 1'b0;
        ticks(half - half / 2);
      end else begin
        ticks(half);
      end
      if (f == 1) got[0] = ps2DQI;
      dev_ck = 1'b1;
      ticks(half);
      if (f <= 10) got[f] = ps2DQI;
      if (f == abort_at) return;
      dev_ck = 1'b0;
      if (f == 10 && ack) dev_dq = 1'b1;
    end
    ticks(half);
    dev_dq = 1'b0;
    ticks(4);
  endtask

  task automatic wait_result(input int bd, input int be);
    int w;
    w = 0;
    while (n_done == bd && n_err == be && w < 400) begin ticks(1); w++; end
    checks++;
    if (n_done == bd && n_err == be) begin
      errors++;
      $display("FAIL wait_result: no done/err after %0d ticks", w);
    end
    ticks(3);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    checks++; if (ps2CkOe !== 1'b0) begin errors++; $display("FAIL reset_ckoe: got %b want 0", ps2CkOe); end
    checks++; if (ps2DQOe !== 1'b0) begin errors++; $display("FAIL reset_dqoe: got %b want 0", ps2DQOe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    reset = 1'b0;
    ticks(10);
  endtask

  task automatic test_send_ed();
    logic [10:0] got, exp;
    bit ok;
    int bd, be, bb;
    bd = n_done; be = n_err; bb = busy_bad;
    exp = frame_model(8'hED);
    send_req(8'hED);
    dev_frame(20, 1'b1, 0, 0, got, ok);
    wait_result(bd, be);
    checks++; if (!ok || got !== exp) begin errors++; $display("FAIL ed_bits: got %b want %b ok=%0d", got, exp, ok); end
    checks++; if (last_low_len != int'(INH)) begin errors++; $display("FAIL ed_inhibit_len: got %0d want %0d", last_low_len, INH); end
    checks++; if (n_done - bd != 1) begin errors++; $display("FAIL ed_done_count: got %0d want 1", n_done - bd); end
    checks++; if (n_err - be != 0) begin errors++; $display("FAIL ed_err_count: got %0d want 0", n_err - be); end
    checks++; if (busy_bad - bb != 0) begin errors++; $display("FAIL ed_busy_at_done: got %0d bad samples want 0", busy_bad - bb); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ed_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_parity();
    logic [7:0] bytes_q[2];
    logic [10:0] got, exp;
    bit ok;
    int bd, be;
    bytes_q[0] = 8'h07;
    bytes_q[1] = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      bd = n_done; be = n_err;
      exp = frame_model(bytes_q[k]);
      send_req(bytes_q[k]);
      dev_frame(int'($urandom_range(12, 24)), 1'b1, 0, 0, got, ok);
      wait_result(bd, be);
      checks++; if (!ok || got !== exp) begin errors++; $display("FAIL parity_bits_%h: got %b want %b", bytes_q[k], got, exp); end
      checks++; if (n_done - bd != 1) begin errors++; $display("FAIL parity_done_%h: got %0d want 1", bytes_q[k], n_done - bd); end
    end
  endtask

  task automatic test_noack();
    logic [10:0] got;
    bit ok, all_ok;
    int bd, be, bi;
    bd = n_done; be = n_err; bi = n_inh;
    all_ok = 1'b1;
    send_req(8'($urandom));
    for (int a = 0; a < ATT; a++) begin
      dev_frame(int'($urandom_range(12, 24)), 1'b0, 0, 0, got, ok);
      all_ok &= ok;
    end
    wait_result(bd, be);
    checks++; if (n_err - be != 1 || !all_ok) begin errors++; $display("FAIL noack_err_count: got %0d want 1 ok=%0d", n_err - be, all_ok); end
    checks++; if (n_done - bd != 0) begin errors++; $display("FAIL noack_done_count: got %0d want 0", n_done - bd); end
    checks++; if (n_inh - bi != ATT) begin errors++; $display("FAIL noack_attempts: got %0d want %0d", n_inh - bi, ATT); end
  endtask

  task automatic test_timeout();
    int bd, be, bi, w;
    bd = n_done; be = n_err; bi = n_inh;
    send_req(8'hF3);
    w = 0;
    while (n_err == be && w < ATT * (int'(TO) + int'(INH) + 100)) begin ticks(1); w++; end
    checks++; if (n_err - be != 1) begin errors++; $display("FAIL timeout_err_count: got %0d want 1", n_err - be); end
    checks++; if (err_tick - rel_tick != int'(TO)) begin errors++; $display("FAIL timeout_ticks: got %0d want %0d", err_tick - rel_tick, TO); end
    checks++; if (ps2CkOe !== 1'b0 || ps2DQOe !== 1'b0) begin errors++; $display("FAIL timeout_release: got ck=%b dq=%b want 0 0", ps2CkOe, ps2DQOe); end
    checks++; if (n_inh - bi != ATT) begin errors++; $display("FAIL timeout_attempts: got %0d want %0d", n_inh - bi, ATT); end
    checks++; if (n_done - bd != 0) begin errors++; $display("FAIL timeout_done_count: got %0d want 0", n_done - bd); end
    ticks(3);
  endtask

  task automatic test_reset_mid();
    logic [10:0] got, exp;
    bit ok;
    int bd, be;
    bd = n_done; be = n_err;
    send_req(8'h3C);
    dev_frame(20, 1'b1, 0, 5, got, ok);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checks++; if (ps2CkOe !== 1'b0 || ps2DQOe !== 1'b0) begin errors++; $display("FAIL midreset_lines: got ck=%b dq=%b want 0 0", ps2CkOe, ps2DQOe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL midreset_pulse: got done=%b err=%b want 0 0", done, err); end
    reset = 1'b0;
    dev_ck = 1'b0;
    dev_dq = 1'b0;
    ticks(20);
    checks++; if (n_done != bd || n_err != be) begin errors++; $display("FAIL midreset_no_pulse: got done+%0d err+%0d want 0 0", n_done - bd, n_err - be); end
    bd = n_done; be = n_err;
    exp = frame_model(8'hF4);
    send_req(8'hF4);
    dev_frame(18, 1'b1, 0, 0, got, ok);
    wait_result(bd, be);
    checks++; if (!ok || got !== exp) begin errors++; $display("FAIL after_reset_bits: got %b want %b", got, exp); end
    checks++; if (n_done - bd != 1) begin errors++; $display("FAIL after_reset_done: got %0d want 1", n_done - bd); end
  endtask

  task automatic test_busy_glitch();
    logic [10:0] got, exp;
    bit ok;
    int bd, be, bi;
    bd = n_done; be = n_err; bi = n_inh;
    exp = frame_model(8'hA3);
    send_req(8'hA3);
    ticks(5);
    data = 8'h55;
    strb = 1'b1;
    ticks(1);
    strb = 1'b0;
    dev_frame(20, 1'b1, 4, 0, got, ok);
    wait_result(bd, be);
    checks++; if (!ok || got !== exp) begin errors++; $display("FAIL busy_glitch_bits: got %b want %b", got, exp); end
    checks++; if (n_done - bd != 1) begin errors++; $display("FAIL busy_glitch_done: got %0d want 1", n_done - bd); end
    checks++; if (n_inh - bi != 1) begin errors++; $display("FAIL busy_glitch_restart: got %0d inhibits want 1", n_inh - bi); end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic [10:0] got, exp;
    bit ok;
    int bd, be;
    for (int k = 0; k < 6; k++) begin
      d = 8'($urandom);
      bd = n_done; be = n_err;
      exp = frame_model(d);
      send_req(d);
      dev_frame(int'($urandom_range(12, 24)), 1'b1, 0, 0, got, ok);
      wait_result(bd, be);
      checks++; if (!ok || got !== exp) begin errors++; $display("FAIL random_bits_%h: got %b want %b", d, got, exp); end
      checks++; if (n_done - bd != 1) begin errors++; $display("FAIL random_done_%h: got %0d want 1", d, n_done - bd); end
    end
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_parity();
    test_noack();
    test_timeout();
    test_reset_mid();
    test_busy_glitch();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
